// File: rtl/isr_arb_pkg.sv
// Shared types and widths for the ISR arbiter: FSM states, ISR bus widths,
// and the wait-counter width helper.
package isr_arb_pkg;

  localparam int unsigned ISR_IN_W  = 64;
  localparam int unsigned ISR_OUT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Counter must be able to hold the value max_wait itself
  function automatic int unsigned cnt_w(input int unsigned max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/isr_arbiter_rr_pick.sv
// Combinational N-way round-robin selector: first asserted request at or
// after ptr, wrapping, returned as one-hot grant and binary index.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    any   = |req;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/isr_arbiter.sv
// Shares one external ISR (64-bit integer square root) between N requesters
// with round-robin fairness and a WAIT-state timeout.
module isr_arbiter
  import isr_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_WAIT = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [N*ISR_IN_W-1:0] req_value,
  output logic [N-1:0]          gnt,
  output logic [N-1:0]          resp_valid,
  output logic [ISR_OUT_W-1:0]  resp_result,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  isr_reset,
  output logic [ISR_IN_W-1:0]   isr_value,
  input  logic [ISR_OUT_W-1:0]  isr_result,
  input  logic                  isr_done
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = cnt_w(MAX_WAIT);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, owner_q, ptr_next;
  logic [ISR_IN_W-1:0]  operand_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [ISR_OUT_W-1:0] result_q;
  logic                 err_q;

  logic [N-1:0]         pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [ISR_IN_W-1:0]  req_ops [N];

  logic take, clr_cnt, done_hit, timeout_hit;

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      req_ops[i] = req_value[i*ISR_IN_W +: ISR_IN_W];
    end
  end

  assign ptr_next = (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + 1'b1;

  // Next-state and state-decoded outputs
  always_comb begin
    state_d     = state_q;
    gnt         = '0;
    resp_valid  = '0;
    busy        = 1'b0;
    isr_reset   = 1'b1;
    take        = 1'b0;
    clr_cnt     = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt     = pick_gnt;
          take    = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy    = 1'b1;
        clr_cnt = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        busy      = 1'b1;
        isr_reset = 1'b0;
        if (isr_done) begin
          done_hit = 1'b1;
          state_d  = RESP;
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        busy                = 1'b1;
        resp_valid[owner_q] = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      operand_q <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        operand_q <= req_ops[pick_idx];
        owner_q   <= pick_idx;
        ptr_q     <= ptr_next;
      end
      if (clr_cnt) begin
        cnt_q <= '0;
      end else if (state_q == WAIT && !isr_done) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Done takes priority over a coincident timeout
      if (done_hit) begin
        result_q <= isr_result;
        err_q    <= 1'b0;
      end else if (timeout_hit) begin
        result_q <= '0;
        err_q    <= 1'b1;
      end
    end
  end

  assign resp_result = result_q;
  assign resp_err    = err_q;
  assign isr_value   = operand_q;

endmodule

// File: tb/tb_isr_arbiter.sv
// Self-checking bench for isr_arbiter: behavioural ISR model, table vectors,
// randomized round-robin traffic, abort-by-reset and a timeout instance.
module tb_isr_arbiter;

  localparam int unsigned N = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req, gnt, resp_valid;
  logic [N*64-1:0] req_value;
  logic [31:0]     resp_result, isr_result;
  logic            resp_err, busy, isr_reset, isr_done;
  logic [63:0]     isr_value;

  logic [N-1:0]    req_t, gnt_t, resp_valid_t;
  logic [N*64-1:0] req_value_t;
  logic [31:0]     resp_result_t;
  logic            resp_err_t, busy_t, isr_reset_t;
  logic [63:0]     isr_value_t;
  logic [31:0]     isr_result_t;
  logic            isr_done_t;

  int          passed = 0;
  int          total  = 0;
  int          ptr    = 0;
  logic [63:0] vals [N];
  bit          slow   = 1'b0;
  int unsigned lat    = 0;
  int unsigned icnt   = 0;

  always #5 clock = ~clock;

  isr_arbiter #(.N(N), .MAX_WAIT(1023)) dut (
    .clock(clock), .reset(reset), .req(req), .req_value(req_value),
    .gnt(gnt), .resp_valid(resp_valid), .resp_result(resp_result),
    .resp_err(resp_err), .busy(busy), .isr_reset(isr_reset),
    .isr_value(isr_value), .isr_result(isr_result), .isr_done(isr_done)
  );

  isr_arbiter #(.N(N), .MAX_WAIT(8)) dut_t (
    .clock(clock), .reset(reset), .req(req_t), .req_value(req_value_t),
    .gnt(gnt_t), .resp_valid(resp_valid_t), .resp_result(resp_result_t),
    .resp_err(resp_err_t), .busy(busy_t), .isr_reset(isr_reset_t),
    .isr_value(isr_value_t), .isr_result(isr_result_t), .isr_done(isr_done_t)
  );

  // Stub ISR for the timeout instance: never finishes
  assign isr_done_t   = 1'b0;
  assign isr_result_t = 32'hDEAD_BEEF;

  function automatic logic [31:0] isqrt(input logic [63:0] v);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'hFFFF_FFFF;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return 32'(lo);
  endfunction

  // Behavioural ISR: done rises a random number of cycles after release
  always @(posedge clock) begin
    if (isr_reset) begin
      icnt     <= 0;
      isr_done <= 1'b0;
      lat      <= slow ? 300 : $urandom_range(0, 6);
    end else begin
      icnt <= icnt + 1;
      if (icnt >= lat) isr_done <= 1'b1;
    end
  end
  assign isr_result = isqrt(isr_value);

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic apply_vals();
    for (int i = 0; i < N; i++) req_value[i*64 +: 64] = vals[i];
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    req   = '0;
    req_t = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    ptr = 0;
  endtask

  // Called just after a posedge with req set; returns just after the RESP edge
  task automatic serve_one(input int own, input logic [31:0] exp_res, input bit drop);
    int n;
    logic [N-1:0] oh;
    oh = '0;
    oh[own] = 1'b1;
    n = 0;
    @(negedge clock);
    while (gnt == '0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("gnt", 64'(gnt), 64'(oh));
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_isr_reset", 64'(isr_reset), 64'd1);
    chk("idle_resp_valid", 64'(resp_valid), 64'd0);
    if (gnt == '0) return;
    ptr = (own + 1) % N;
    @(posedge clock); #1;
    if (drop) req[own] = 1'b0;
    @(negedge clock);
    chk("load_busy", 64'(busy), 64'd1);
    chk("load_isr_reset", 64'(isr_reset), 64'd1);
    chk("load_isr_value", isr_value, vals[own]);
    chk("load_gnt", 64'(gnt), 64'd0);
    @(negedge clock);
    chk("wait_isr_reset", 64'(isr_reset), 64'd0);
    n = 0;
    while (resp_valid == '0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("resp_valid", 64'(resp_valid), 64'(oh));
    chk("resp_result", 64'(resp_result), 64'(exp_res));
    chk("resp_err", 64'(resp_err), 64'd0);
    chk("resp_busy", 64'(busy), 64'd1);
    @(posedge clock); #1;
  endtask

  typedef struct {
    int          who;
    logic [63:0] val;
    logic [31:0] res;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int own;
    int n;
    logic [N-1:0] newm;
    logic [31:0] r;
    logic seen;

    tbl[0] = '{0, 64'd9, 32'd3};
    tbl[1] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF};
    tbl[2] = '{2, 64'd0, 32'd0};
    tbl[3] = '{1, 64'd258, 32'd16};
    tbl[4] = '{3, 64'd1, 32'd1};
    tbl[5] = '{0, 64'h0000_0001_0000_0000, 32'd65536};
    tbl[6] = '{1, 64'd15, 32'd3};
    tbl[7] = '{3, 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF};

    reset       = 1'b1;
    req         = '0;
    req_t       = '0;
    req_value   = '0;
    req_value_t = '0;
    for (int i = 0; i < N; i++) vals[i] = '0;
    repeat (3) @(negedge clock);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_result", 64'(resp_result), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_isr_reset", 64'(isr_reset), 64'd1);
    chk("rst_isr_value", isr_value, 64'd0);
    chk("rst_t_busy", 64'(busy_t), 64'd0);
    @(posedge clock); #1 reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      vals[tbl[i].who] = tbl[i].val;
      apply_vals();
      req[tbl[i].who] = 1'b1;
      serve_one(tbl[i].who, tbl[i].res, 1'b1);
    end

    // Simultaneous pair from pointer 0
    do_reset();
    vals[0] = 64'd121;
    vals[1] = 64'd258;
    apply_vals();
    req = 4'b0011;
    serve_one(0, 32'd11, 1'b1);
    serve_one(1, 32'd16, 1'b1);

    // All requesters held high: strict rotation
    do_reset();
    for (int i = 0; i < N; i++) vals[i] = 64'(1000 * (i + 1) * (i + 1));
    apply_vals();
    req = '1;
    for (int i = 0; i < 8; i++) begin
      serve_one(i % N, isqrt(vals[i % N]), 1'b0);
    end
    req = '0;

    // Randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      newm = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (newm[i] && !req[i]) begin
          r = $urandom;
          case ($urandom_range(0, 2))
            0: vals[i] = 64'($urandom_range(0, 5000));
            1: vals[i] = {$urandom, $urandom};
            default: vals[i] = 64'(r) * 64'(r);
          endcase
          req[i] = 1'b1;
        end
      end
      if (req == '0) begin
        vals[0] = 64'd49;
        req[0]  = 1'b1;
      end
      apply_vals();
      own = pick(req, ptr);
      serve_one(own, isqrt(vals[own]), 1'b1);
    end
    req = '0;

    // Reset during WAIT aborts the operation
    do_reset();
    slow    = 1'b1;
    vals[3] = 64'd777;
    apply_vals();
    req[3] = 1'b1;
    @(negedge clock);
    chk("abort_gnt", 64'(gnt), 64'h8);
    @(posedge clock); #1 req[3] = 1'b0;
    repeat (4) @(negedge clock);
    chk("abort_in_wait", 64'(isr_reset), 64'd0);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    ptr  = 0;
    slow = 1'b0;
    @(negedge clock);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_isr_reset", 64'(isr_reset), 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (resp_valid != '0) seen = 1'b1;
      @(negedge clock);
    end
    chk("abort_no_resp", 64'(seen), 64'd0);
    @(posedge clock); #1;
    vals[1] = 64'd25;
    vals[3] = 64'd1000000;
    apply_vals();
    req = 4'b1010;
    serve_one(1, 32'd5, 1'b1);
    serve_one(3, 32'd1000, 1'b1);

    // Timeout instance with MAX_WAIT=8 and a stub ISR
    req_value_t[63:0] = 64'd100;
    req_t = 4'b0001;
    @(negedge clock);
    chk("to_gnt", 64'(gnt_t), 64'd1);
    @(posedge clock); #1 req_t = '0;
    @(negedge clock);
    chk("to_load_busy", 64'(busy_t), 64'd1);
    chk("to_load_value", isr_value_t, 64'd100);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (isr_reset_t == 1'b0 && resp_valid_t == '0) n++;
    end
    chk("to_wait_cycles", 64'(n), 64'd8);
    @(negedge clock);
    chk("to_resp_valid", 64'(resp_valid_t), 64'd1);
    chk("to_resp_result", 64'(resp_result_t), 64'd0);
    chk("to_resp_err", 64'(resp_err_t), 64'd1);
    @(negedge clock);
    chk("to_idle_busy", 64'(busy_t), 64'd0);
    chk("to_idle_resp_valid", 64'(resp_valid_t), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
